// File: rtl/bp_fetch_ctrl.sv
// Fetch-side next-PC controller: owns the PC, queues in-flight predictions and redirects on mispredict.
// Optional branch/mispredict statistics counters are enabled with `define BP_STATS_EN.
module bp_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          PTR_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        pred_valid_i,
    input  logic        bp_result_i,
    input  logic [31:0] bp_jump_addr_i,
    input  logic        resolve_valid_i,
    input  logic        resolve_taken_i,
    input  logic [31:0] resolve_addr_i,
    output logic [31:0] pc_o,
    output logic        fetch_stall_o,
    output logic        flush_o,
    output logic        last_jump_o,
    output logic [31:0] last_addr_o,
`ifdef BP_STATS_EN
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o,
`endif
    output logic        last_need_predict_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      fifo_pc    [DEPTH];
    logic             fifo_taken [DEPTH];
    logic [31:0]      fifo_tgt   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic        push, pop, mispredict;
    logic [31:0] head_pc, head_tgt, correct_pc, next_pc;
    logic        head_taken;

    always_comb begin
        head_pc       = fifo_pc[rd_ptr];
        head_taken    = fifo_taken[rd_ptr];
        head_tgt      = fifo_tgt[rd_ptr];
        fetch_stall_o = (count == FULL_CNT);
        pop           = resolve_valid_i & (count != '0);
        mispredict    = pop & ((head_taken != resolve_taken_i) |
                               (head_taken & resolve_taken_i & (head_tgt != resolve_addr_i)));
        flush_o       = jump_flag_i | mispredict;
        push          = pred_valid_i & ~hold_i & ~fetch_stall_o & ~flush_o;
        correct_pc    = resolve_taken_i ? resolve_addr_i : head_pc + 32'd4;

        if (jump_flag_i)                       next_pc = jump_addr_i;
        else if (mispredict)                   next_pc = correct_pc;
        else if (hold_i | fetch_stall_o)       next_pc = pc_o;
        else if (pred_valid_i & bp_result_i)   next_pc = bp_jump_addr_i;
        else                                   next_pc = pc_o + 32'd4;
    end

    // Prediction storage is data only; validity is carried by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc_o;
            fifo_taken[wr_ptr] <= bp_result_i;
            fifo_tgt[wr_ptr]   <= bp_jump_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_o                <= RESET_ADDR;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            last_jump_o         <= 1'b0;
            last_addr_o         <= 32'd0;
            last_need_predict_o <= 1'b0;
        end else begin
            pc_o                <= next_pc;
            last_need_predict_o <= pop;
            if (pop) begin
                last_jump_o <= resolve_taken_i;
                last_addr_o <= head_pc;
            end
            // A flush squashes everything younger, so the queue simply restarts empty.
            if (flush_o) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_cnt_o      <= 32'd0;
            mispred_cnt_o <= 32'd0;
        end else begin
            if (pop && br_cnt_o != 32'hFFFF_FFFF)
                br_cnt_o <= br_cnt_o + 32'd1;
            if (mispredict && mispred_cnt_o != 32'hFFFF_FFFF)
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end
`endif

endmodule
